alu_cc_stage: RTL and testbench

Registered, width-parametrised ALU stage with a valid/ready handshake and an architectural condition-code register (ZF/SF/OF). It sits in the Y-86 execute stage. It computes the four OPq functions (and, xor, add, sub) plus carry/borrow, holds each result until the consumer accepts it, and evaluates jXX/cmovXX conditions from the stored flags. It supersedes the fixed 64-bit combinational ALU for pipelined and narrower-width builds.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_core.sv | 53 +++++
 rtl/alu_cc_stage.sv | 98 +++++++++
 tb/tb_alu_cc_stage.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: function codes, jXX/cmovXX conditions, CC reset value.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package alu_pkg;

  // OPq function select
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_XOR = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  // Y-86 condition selectors; 3'd7 is unused and evaluates false
  localparam logic [2:0] C_ALWAYS = 3'd0;
  localparam logic [2:0] C_LE     = 3'd1;
  localparam logic [2:0] C_L      = 3'd2;
  localparam logic [2:0] C_E      = 3'd3;
  localparam logic [2:0] C_NE     = 3'd4;
  localparam logic [2:0] C_GE     = 3'd5;
  localparam logic [2:0] C_G      = 3'd6;

  // {ZF,SF,OF} after reset: "equal", so je is taken before any compare
  localparam logic [2:0] CC_RST_DEFAULT = 3'b100;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  function automatic logic cond_eval(input logic [2:0] sel, input cc_t cc);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (sel)
      C_ALWAYS: cond_eval = 1'b1;
      C_LE:     cond_eval = lt | cc.zf;
      C_L:      cond_eval = lt;
      C_E:      cond_eval = cc.zf;
      C_NE:     cond_eval = !cc.zf;
      C_GE:     cond_eval = !lt;
      C_G:      cond_eval = !lt && !cc.zf;
      default:  cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational OPq datapath: and/xor/add/sub with carry/borrow and ZF/SF/OF.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage decides when results are captured.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       fn,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;
  logic           a_msb;
  logic           b_msb;

  // One extra bit captures carry-out for add; for sub the top bit is set exactly when a < b
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign a_msb  = a[WIDTH-1];
  assign b_msb  = b[WIDTH-1];

  // Select the function result and derive flags from it
  always_comb begin
    res   = '0;
    carry = 1'b0;
    of    = 1'b0;
    case (fn)
      ALU_AND: res = a & b;
      ALU_XOR: res = a ^ b;
      ALU_ADD: begin
        res   = sum_w[WIDTH-1:0];
        carry = sum_w[WIDTH];
        of    = (a_msb == b_msb) && (sum_w[WIDTH-1] != a_msb);
      end
      default: begin
        res   = diff_w[WIDTH-1:0];
        carry = diff_w[WIDTH];
        of    = (a_msb != b_msb) && (diff_w[WIDTH-1] != a_msb);
      end
    endcase
    zf = (res == '0);
    sf = res[WIDTH-1];
  end

endmodule

// File: rtl/alu_cc_stage.sv
// Registered ALU stage with valid/ready handshake and architectural ZF/SF/OF register.
// Latency: 1 cycle accept-to-result; 1 beat/cycle while out_ready is high.
// Backpressure: in_ready drops while a held result is not consumed or flush is asserted.
module alu_cc_stage
  import alu_pkg::*;
#(
  parameter int         WIDTH  = 64,
  parameter logic [2:0] CC_RST = CC_RST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       fn,
  input  logic             set_cc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zf,
  output logic             sf,
  output logic             of,
  input  logic [2:0]       cond_fn,
  output logic             cond_true
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  cc_t              cc_q, cc_d;

  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  cc_t              core_cc;
  logic             accept;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (a),
    .b     (b),
    .fn    (fn),
    .res   (core_res),
    .carry (core_carry),
    .zf    (core_cc.zf),
    .sf    (core_cc.sf),
    .of    (core_cc.of)
  );

  // A slot frees up in the same cycle the consumer takes the held result; flush blocks intake
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state: load on accept, otherwise drop valid on drain or flush; data persists
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    cc_d        = cc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_res;
      carry_d     = core_carry;
      if (set_cc) begin
        cc_d = core_cc;
      end
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and condition-code register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      cc_q        <= cc_t'(CC_RST);
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zf        = cc_q.zf;
  assign sf        = cc_q.sf;
  assign of        = cc_q.of;
  assign cond_true = cond_eval(cond_fn, cc_q);

endmodule

// File: tb/tb_alu_cc_stage.sv
// Bench for alu_cc_stage: a 64-bit and an 8-bit instance against an arithmetic reference model.
// Directed beats pin literal values; a long random phase is checked every cycle.
module tb_alu_cc_stage;

  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic        z;
    logic        s;
    logic        o;
  } mres_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0 drives the WIDTH=64 instance, index 1 the WIDTH=8 instance
  logic [1:0]       in_valid, flush, set_cc, out_ready;
  logic [1:0][63:0] a_v, b_v;
  logic [1:0][1:0]  fn_v;
  logic [1:0][2:0]  cond_v;
  logic [1:0]       in_ready_o, out_valid_o, carry_o, zf_o, sf_o, of_o, cond_o;
  logic [63:0]      res64;
  logic [7:0]       res8;

  alu_cc_stage #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_o[0]),
    .a(a_v[0]), .b(b_v[0]), .fn(fn_v[0]), .set_cc(set_cc[0]), .flush(flush[0]),
    .out_valid(out_valid_o[0]), .out_ready(out_ready[0]), .result(res64),
    .carry(carry_o[0]), .zf(zf_o[0]), .sf(sf_o[0]), .of(of_o[0]),
    .cond_fn(cond_v[0]), .cond_true(cond_o[0])
  );

  alu_cc_stage #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_o[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .fn(fn_v[1]), .set_cc(set_cc[1]), .flush(flush[1]),
    .out_valid(out_valid_o[1]), .out_ready(out_ready[1]), .result(res8),
    .carry(carry_o[1]), .zf(zf_o[1]), .sf(sf_o[1]), .of(of_o[1]),
    .cond_fn(cond_v[1]), .cond_true(cond_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking_on = 1'b0;

  function automatic int wid(input int k);
    return (k == 0) ? 64 : 8;
  endfunction

  function automatic logic [63:0] act_res(input int k);
    return (k == 0) ? res64 : {56'd0, res8};
  endfunction

  // Reference arithmetic: signed overflow judged by range, not by sign-bit rules
  function automatic mres_t model_alu(input int w, input logic [63:0] a, input logic [63:0] b,
                                      input logic [1:0] f);
    mres_t r;
    logic [63:0] mask, am, bm;
    logic [65:0] u;
    logic signed [65:0] sa, sb, sr, lim;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am = a & mask;
    bm = b & mask;
    sa = $signed({2'b00, am});
    sb = $signed({2'b00, bm});
    if (am[w-1]) sa = sa - (66'sd1 <<< w);
    if (bm[w-1]) sb = sb - (66'sd1 <<< w);
    lim = 66'sd1 <<< (w - 1);
    r = '0;
    sr = '0;
    case (f)
      2'd0: r.res = am & bm;
      2'd1: r.res = am ^ bm;
      2'd2: begin
        u = {2'b00, am} + {2'b00, bm};
        r.res = u[63:0] & mask;
        r.c = u[w];
        sr = sa + sb;
        r.o = (sr >= lim) || (sr < -lim);
      end
      default: begin
        r.res = (am - bm) & mask;
        r.c = (am < bm);
        sr = sa - sb;
        r.o = (sr >= lim) || (sr < -lim);
      end
    endcase
    r.z = (r.res == 64'd0);
    r.s = r.res[w-1];
    return r;
  endfunction

  function automatic logic model_cond(input logic [2:0] c, input logic z, input logic s,
                                      input logic o);
    case (c)
      3'd0: return 1'b1;
      3'd1: return (s != o) || z;
      3'd2: return s != o;
      3'd3: return z;
      3'd4: return !z;
      3'd5: return s == o;
      3'd6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] rand_op(input int w);
    logic [63:0] mask, minv;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    minv = 64'd1 << (w - 1);
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return mask;
      2: return minv;
      3: return minv - 64'd1;
      4: return 64'($urandom_range(0, 7));
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Model state: what the outputs must hold after each edge
  logic [1:0]       m_valid, m_c, m_z, m_s, m_o;
  logic [1:0][63:0] m_res;

  function automatic logic m_ready(input int k);
    return !flush[k] && (!m_valid[k] || out_ready[k]);
  endfunction

  // Advance the reference model on each edge using the inputs offered in that cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= '0;
      m_res   <= '0;
      m_c     <= '0;
      m_z     <= 2'b11;
      m_s     <= '0;
      m_o     <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (in_valid[k] && m_ready(k)) begin
          m_valid[k] <= 1'b1;
          m_res[k]   <= model_alu(wid(k), a_v[k], b_v[k], fn_v[k]).res;
          m_c[k]     <= model_alu(wid(k), a_v[k], b_v[k], fn_v[k]).c;
          if (set_cc[k]) begin
            m_z[k] <= model_alu(wid(k), a_v[k], b_v[k], fn_v[k]).z;
            m_s[k] <= model_alu(wid(k), a_v[k], b_v[k], fn_v[k]).s;
            m_o[k] <= model_alu(wid(k), a_v[k], b_v[k], fn_v[k]).o;
          end
        end else if (flush[k] || out_ready[k]) begin
          m_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Compare every output of both instances against the model, mid-cycle
  always @(negedge clk) begin
    if (checking_on) begin
      for (int k = 0; k < 2; k++) begin
        check("in_ready",  k, 64'(in_ready_o[k]),  64'(m_ready(k)));
        check("out_valid", k, 64'(out_valid_o[k]), 64'(m_valid[k]));
        check("result",    k, act_res(k),          m_res[k]);
        check("carry",     k, 64'(carry_o[k]),     64'(m_c[k]));
        check("zf",        k, 64'(zf_o[k]),        64'(m_z[k]));
        check("sf",        k, 64'(sf_o[k]),        64'(m_s[k]));
        check("of",        k, 64'(of_o[k]),        64'(m_o[k]));
        check("cond_true", k, 64'(cond_o[k]),
              64'(model_cond(cond_v[k], m_z[k], m_s[k], m_o[k])));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    flush     = '0;
    set_cc    = '0;
    out_ready = 2'b11;
    a_v       = '0;
    b_v       = '0;
    fn_v      = '0;
    cond_v[0] = 3'd3;
    cond_v[1] = 3'd3;
    repeat (2) tick();
    checking_on = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 0, 64'(out_valid_o[0]), 64'd0);
    check("rst_result",    0, res64, 64'd0);
    check("rst_flags",     0, 64'({zf_o[0], sf_o[0], of_o[0]}), 64'b100);
    check("rst_cond_e",    0, 64'(cond_o[0]), 64'd1);

    // Add overflow on 64-bit; 0x80+0x80 on 8-bit
    tick();
    rst_n     = 1'b1;
    in_valid  = 2'b11;
    a_v[0]    = 64'h7FFF_FFFF_FFFF_FFFF;
    b_v[0]    = 64'd1;
    a_v[1]    = 64'h80;
    b_v[1]    = 64'h80;
    fn_v[0]   = 2'b10;
    fn_v[1]   = 2'b10;
    set_cc    = 2'b11;
    cond_v[0] = 3'd2;
    cond_v[1] = 3'd1;
    tick();
    in_valid = 2'b00;
    @(negedge clk);
    check("addov_result", 0, res64, 64'h8000_0000_0000_0000);
    check("addov_carry",  0, 64'(carry_o[0]), 64'd0);
    check("addov_flags",  0, 64'({zf_o[0], sf_o[0], of_o[0]}), 64'b011);
    check("addov_cond_l", 0, 64'(cond_o[0]), 64'd0);
    check("w8_result",    1, 64'(res8), 64'd0);
    check("w8_carry",     1, 64'(carry_o[1]), 64'd1);
    check("w8_flags",     1, 64'({zf_o[1], sf_o[1], of_o[1]}), 64'b101);
    check("w8_cond_le",   1, 64'(cond_o[1]), 64'd1);

    // Sub with borrow, flags untouched; 8-bit g condition
    tick();
    cond_v[1]   = 3'd6;
    in_valid[0] = 1'b1;
    a_v[0]      = 64'd3;
    b_v[0]      = 64'd5;
    fn_v[0]     = 2'b11;
    set_cc[0]   = 1'b0;
    @(negedge clk);
    check("w8_cond_g", 1, 64'(cond_o[1]), 64'd0);
    tick();
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("sub_result", 0, res64, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_carry",  0, 64'(carry_o[0]), 64'd1);
    check("sub_flags",  0, 64'({zf_o[0], sf_o[0], of_o[0]}), 64'b011);

    // Backpressure: hold for 3 cycles, then release together with a pending beat
    tick();
    in_valid[0]  = 1'b1;
    a_v[0]       = 64'd10;
    b_v[0]       = 64'd20;
    fn_v[0]      = 2'b10;
    set_cc[0]    = 1'b1;
    out_ready[0] = 1'b0;
    tick();
    a_v[0]  = 64'd100;
    b_v[0]  = 64'd1;
    fn_v[0] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_result",   0, res64, 64'd30);
      check("bp_in_ready", 0, 64'(in_ready_o[0]), 64'd0);
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    @(negedge clk);
    check("bp_next_valid",  0, 64'(out_valid_o[0]), 64'd1);
    check("bp_next_result", 0, res64, 64'd99);

    // Flush with a beat offered: no accept, flags unchanged
    tick();
    flush[0]    = 1'b1;
    in_valid[0] = 1'b1;
    a_v[0]      = 64'd0;
    b_v[0]      = 64'd0;
    fn_v[0]     = 2'b00;
    @(negedge clk);
    check("fl_in_ready", 0, 64'(in_ready_o[0]), 64'd0);
    tick();
    flush[0]     = 1'b0;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("fl_out_valid", 0, 64'(out_valid_o[0]), 64'd0);
    check("fl_zf",        0, 64'(zf_o[0]), 64'd0);
    check("fl_result",    0, res64, 64'd99);

    // Random traffic with one asynchronous reset mid-stream
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (cyc == 1500) begin
        #2;
        rst_n = 1'b0;
      end
      if (cyc == 1502) rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        out_ready[k] = ($urandom_range(0, 3) != 0);
        flush[k]     = ($urandom_range(0, 15) == 0);
        set_cc[k]    = $urandom_range(0, 1) != 0;
        fn_v[k]      = 2'($urandom_range(0, 3));
        cond_v[k]    = 3'($urandom_range(0, 7));
        a_v[k]       = rand_op(wid(k));
        b_v[k]       = rand_op(wid(k));
      end
    end
    tick();
    in_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    checking_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
